// File: rtl/mem_wb_writeback_if.sv
// Bundle of pipeline-side, SRAM-side and register-file-side signals for the
// memory/write-back stage. The unit sits on the slave modport; the pipeline,
// SRAM and register file together form the master side.
// Handshake: ready is combinational; while ready = 0 the upstream pipeline
// must hold every input stable, and the instruction is accepted on the rising
// edge where ready = 1.
interface mem_wb_writeback_if #(
  parameter int SRAM_AW = 18
);
  logic               mem_r_en;
  logic               mem_w_en;
  logic               wb_en_in;
  logic [3:0]         dest_in;
  logic [31:0]        alu_result;
  logic [31:0]        st_val;
  logic               ready;
  logic [SRAM_AW-1:0] sram_addr;
  logic [15:0]        sram_dq_out;
  logic [15:0]        sram_dq_in;
  logic               sram_dq_oe;
  logic               sram_we_n;
  logic               wb_en;
  logic [3:0]         wb_dest;
  logic [31:0]        wb_value;

  modport slave (
    input  mem_r_en, mem_w_en, wb_en_in, dest_in, alu_result, st_val,
    input  sram_dq_in,
    output ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n,
    output wb_en, wb_dest, wb_value
  );

  modport master (
    output mem_r_en, mem_w_en, wb_en_in, dest_in, alu_result, st_val,
    output sram_dq_in,
    input  ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n,
    input  wb_en, wb_dest, wb_value
  );
endinterface

// File: rtl/mem_wb_writeback_unit.sv
// Memory/write-back stage: splits a 32-bit load/store into two half-word
// SRAM phases (low then high), each lasting WAIT_CYCLES clocks, freezes the
// pipeline via ready meanwhile, and owns the MEM/WB register that drives the
// register file write port.
module mem_wb_writeback_unit #(
  parameter int WAIT_CYCLES = 3,
  parameter int ADDR_OFFSET = 1024,
  parameter int SRAM_AW     = 18
) (
  input  logic                 clk,
  input  logic                 rst,
  mem_wb_writeback_if.slave    bus,
  output logic [1:0]           state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LO   = 2'd1,
    S_HI   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_CYCLES - 1);

  state_t             state;
  state_t             state_nxt;
  logic [CW-1:0]      cnt;
  logic [CW-1:0]      cnt_nxt;
  logic [31:0]        rd_data;
  logic               mem_req;
  logic               phase_end;
  logic [31:0]        addr_diff;
  logic [SRAM_AW-2:0] word_addr;
  logic               unused_addr_bits;

  assign mem_req   = bus.mem_r_en | bus.mem_w_en;
  assign phase_end = (cnt == CNT_LAST);
  assign addr_diff = bus.alu_result - 32'(ADDR_OFFSET);
  // Byte address to 32-bit word index; the two byte-lane bits are dropped.
  assign word_addr = addr_diff[SRAM_AW:2];
  assign unused_addr_bits = ^{addr_diff[31:SRAM_AW+1], addr_diff[1:0]};

  // Freeze upstream for any memory op until the access reaches DONE.
  assign bus.ready = !mem_req || (state == S_DONE);
  assign state_dbg = state;

  // State and phase counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic: each SRAM phase lasts WAIT_CYCLES clocks.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE: begin
        cnt_nxt = '0;
        if (mem_req) state_nxt = S_LO;
      end
      S_LO: begin
        if (phase_end) begin
          state_nxt = S_HI;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      S_HI: begin
        if (phase_end) begin
          state_nxt = S_DONE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // SRAM bus outputs decoded from the current phase.
  always_comb begin
    bus.sram_addr   = '0;
    bus.sram_dq_out = 16'h0;
    bus.sram_dq_oe  = 1'b0;
    bus.sram_we_n   = 1'b1;
    case (state)
      S_LO: begin
        bus.sram_addr   = {word_addr, 1'b0};
        bus.sram_dq_out = bus.st_val[15:0];
        bus.sram_dq_oe  = bus.mem_w_en;
        bus.sram_we_n   = !bus.mem_w_en;
      end
      S_HI: begin
        bus.sram_addr   = {word_addr, 1'b1};
        bus.sram_dq_out = bus.st_val[31:16];
        bus.sram_dq_oe  = bus.mem_w_en;
        bus.sram_we_n   = !bus.mem_w_en;
      end
      default: ;
    endcase
  end

  // Load data assembly: capture each half in the last cycle of its phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= 32'h0;
    end else if (bus.mem_r_en && phase_end) begin
      if (state == S_LO) rd_data[15:0]  <= bus.sram_dq_in;
      if (state == S_HI) rd_data[31:16] <= bus.sram_dq_in;
    end
  end

  // MEM/WB register: bubble while frozen, never write R15 (the PC).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.wb_en    <= 1'b0;
      bus.wb_dest  <= 4'h0;
      bus.wb_value <= 32'h0;
    end else if (bus.ready) begin
      bus.wb_en    <= bus.wb_en_in && (bus.dest_in != 4'd15);
      bus.wb_dest  <= bus.dest_in;
      bus.wb_value <= bus.mem_r_en ? rd_data : bus.alu_result;
    end else begin
      bus.wb_en <= 1'b0;
    end
  end

endmodule
